// File: rtl/memsys_pkg.sv
// Shared encodings for the memory_system control sequencer: opcodes, register
// addresses, ALU ops, FSM states and the per-state control vector.
package memsys_pkg;

  localparam int unsigned INSTR_WIDTH    = 5;
  localparam int unsigned REG_ADDR_WIDTH = 3;
  localparam int unsigned STATE_WIDTH    = 5;
  localparam int unsigned SELOP_WIDTH    = 3;
  localparam int unsigned SHAMT_WIDTH    = 2;

  localparam logic [INSTR_WIDTH-1:0] OP_NOP       = 5'b00000;
  localparam logic [INSTR_WIDTH-1:0] OP_MOV_DPTR  = 5'b00001;
  localparam logic [INSTR_WIDTH-1:0] OP_MOV_A_IMM = 5'b00010;
  localparam logic [INSTR_WIDTH-1:0] OP_MOV_A_IND = 5'b00011;
  localparam logic [INSTR_WIDTH-1:0] OP_MOV_IND_A = 5'b00100;
  localparam logic [INSTR_WIDTH-1:0] OP_ADD_IMM   = 5'b00101;
  localparam logic [INSTR_WIDTH-1:0] OP_INC_DPTR  = 5'b00110;
  localparam logic [INSTR_WIDTH-1:0] OP_JZ        = 5'b00111;
  localparam logic [INSTR_WIDTH-1:0] OP_HALT      = 5'b11111;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_PC   = 3'd0;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_DPTR = 3'd2;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_A    = 3'd3;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_TEMP = 3'd4;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ACC  = 3'd5;

  localparam logic [SELOP_WIDTH-1:0] ALU_PASS = 3'b000;
  localparam logic [SELOP_WIDTH-1:0] ALU_ADD  = 3'b001;
  localparam logic [SELOP_WIDTH-1:0] ALU_INC  = 3'b110;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_CLR         = 5'd0,
    S_IDLE        = 5'd1,
    S_F0          = 5'd2,
    S_F1          = 5'd3,
    S_F2          = 5'd4,
    S_DEC         = 5'd5,
    S_IM0         = 5'd6,
    S_IM1         = 5'd7,
    S_WB_DPTR     = 5'd8,
    S_WB_A        = 5'd9,
    S_WB_TEMP     = 5'd10,
    S_WB_PC       = 5'd11,
    S_ADD         = 5'd12,
    S_MAR_DPTR_RD = 5'd13,
    S_MDR_RD      = 5'd14,
    S_MAR_DPTR_WR = 5'd15,
    S_MEM_WR      = 5'd16,
    S_INC_DPTR    = 5'd17,
    S_HLT         = 5'd18
  } state_t;

  typedef struct packed {
    logic                      ir_sclr;
    logic                      mar_sclr;
    logic                      enaf;
    logic                      bank_wr_en;
    logic                      ir_en;
    logic                      mar_en;
    logic                      wr_rdn;
    logic                      mdr_alu_n;
    logic                      mdr_en;
    logic                      halted;
    logic [SELOP_WIDTH-1:0]    selop;
    logic [REG_ADDR_WIDTH-1:0] bus_b;
    logic [REG_ADDR_WIDTH-1:0] bus_c;
  } ctrl_t;

  // MAR <- register r (fetch address / DPTR indirection)
  function automatic ctrl_t ctrl_mar(input logic [REG_ADDR_WIDTH-1:0] r);
    ctrl_t c;
    c        = '0;
    c.mar_en = 1'b1;
    c.bus_b  = r;
    return c;
  endfunction

  // MDR <- M[PC] while PC increments through the ALU
  function automatic ctrl_t ctrl_fetch_data();
    ctrl_t c;
    c            = '0;
    c.mdr_en     = 1'b1;
    c.bank_wr_en = 1'b1;
    c.selop      = ALU_INC;
    c.bus_b      = REG_PC;
    c.bus_c      = REG_PC;
    return c;
  endfunction

  function automatic ctrl_t ctrl_wb(input logic [REG_ADDR_WIDTH-1:0] r);
    ctrl_t c;
    c            = '0;
    c.bank_wr_en = 1'b1;
    c.mdr_alu_n  = 1'b1;
    c.bus_c      = r;
    return c;
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_CLR: begin
        c.ir_sclr  = 1'b1;
        c.mar_sclr = 1'b1;
      end
      S_F0, S_IM0:                  c = ctrl_mar(REG_PC);
      S_F1, S_IM1:                  c = ctrl_fetch_data();
      S_F2:                         c.ir_en = 1'b1;
      S_WB_DPTR:                    c = ctrl_wb(REG_DPTR);
      S_WB_A:                       c = ctrl_wb(REG_A);
      S_WB_TEMP:                    c = ctrl_wb(REG_TEMP);
      S_WB_PC:                      c = ctrl_wb(REG_PC);
      S_ADD: begin
        c.selop      = ALU_ADD;
        c.bus_b      = REG_A;
        c.bus_c      = REG_A;
        c.enaf       = 1'b1;
        c.bank_wr_en = 1'b1;
      end
      S_MAR_DPTR_RD, S_MAR_DPTR_WR: c = ctrl_mar(REG_DPTR);
      S_MDR_RD:                     c.mdr_en = 1'b1;
      S_MEM_WR: begin
        c.wr_rdn = 1'b1;
        c.bus_b  = REG_A;
      end
      S_INC_DPTR: begin
        c.selop      = ALU_INC;
        c.bus_b      = REG_DPTR;
        c.bus_c      = REG_DPTR;
        c.bank_wr_en = 1'b1;
        c.enaf       = 1'b1;
      end
      S_HLT:                        c.halted = 1'b1;
      default:                      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/memsys_sequencer.sv
// Fetch/decode/execute control FSM for memory_system. Every control line is a
// flop loaded from the decode of the next state, so outputs track state_m exactly.
module memsys_sequencer
  import memsys_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [INSTR_WIDTH-1:0]    instruction,
  input  logic                      C,
  input  logic                      N,
  input  logic                      P,
  input  logic                      Z,
  output logic                      ir_sclr,
  output logic                      mar_sclr,
  output logic                      enaf,
  output logic                      bank_wr_en,
  output logic                      ir_en,
  output logic                      mar_en,
  output logic                      wr_rdn,
  output logic                      mdr_alu_n,
  output logic                      mdr_en,
  output logic [SELOP_WIDTH-1:0]    selop,
  output logic [SHAMT_WIDTH-1:0]    shamt,
  output logic [REG_ADDR_WIDTH-1:0] busB_addr,
  output logic [REG_ADDR_WIDTH-1:0] busC_addr,
  output logic                      halted,
  output logic                      illegal,
  output logic [STATE_WIDTH-1:0]    state_m
);

  state_t state;
  state_t next_state;
  state_t instr_end;
  ctrl_t  ctrl_q;
  logic   illegal_q;
  logic   illegal_nxt;

  // Only Z steers the sequence; the remaining flags are observed by software.
  logic unused_flags;
  assign unused_flags = ^{C, N, P};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLR;
      ctrl_q    <= ctrl_of(S_CLR);
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      ctrl_q    <= ctrl_of(next_state);
      illegal_q <= illegal_nxt;
    end
  end

  always_comb begin
    next_state  = state;
    illegal_nxt = illegal_q;
    instr_end   = run ? S_F0 : S_IDLE;
    case (state)
      S_CLR:  next_state = S_IDLE;
      S_IDLE: if (run) next_state = S_F0;
      S_F0:   next_state = S_F1;
      S_F1:   next_state = S_F2;
      S_F2:   next_state = S_DEC;
      S_DEC: begin
        case (instruction)
          OP_NOP:                                    next_state = instr_end;
          OP_MOV_DPTR, OP_MOV_A_IMM, OP_ADD_IMM, OP_JZ: next_state = S_IM0;
          OP_MOV_A_IND:                              next_state = S_MAR_DPTR_RD;
          OP_MOV_IND_A:                              next_state = S_MAR_DPTR_WR;
          OP_INC_DPTR:                               next_state = S_INC_DPTR;
          OP_HALT:                                   next_state = S_HLT;
          default: begin
            next_state  = S_HLT;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      S_IM0: next_state = S_IM1;
      // MDR now holds the immediate; IR still holds the opcode.
      S_IM1: begin
        case (instruction)
          OP_MOV_DPTR:  next_state = S_WB_DPTR;
          OP_MOV_A_IMM: next_state = S_WB_A;
          OP_ADD_IMM:   next_state = S_WB_TEMP;
          OP_JZ:        next_state = Z ? S_WB_PC : instr_end;
          default:      next_state = instr_end;
        endcase
      end
      S_WB_TEMP:     next_state = S_ADD;
      S_MAR_DPTR_RD: next_state = S_MDR_RD;
      S_MDR_RD:      next_state = S_WB_A;
      S_MAR_DPTR_WR: next_state = S_MEM_WR;
      S_WB_DPTR, S_WB_A, S_WB_PC, S_ADD, S_MEM_WR, S_INC_DPTR:
                     next_state = instr_end;
      S_HLT:         next_state = S_HLT;
      default:       next_state = S_CLR;
    endcase
  end

  assign ir_sclr    = ctrl_q.ir_sclr;
  assign mar_sclr   = ctrl_q.mar_sclr;
  assign enaf       = ctrl_q.enaf;
  assign bank_wr_en = ctrl_q.bank_wr_en;
  assign ir_en      = ctrl_q.ir_en;
  assign mar_en     = ctrl_q.mar_en;
  assign wr_rdn     = ctrl_q.wr_rdn;
  assign mdr_alu_n  = ctrl_q.mdr_alu_n;
  assign mdr_en     = ctrl_q.mdr_en;
  assign selop      = ctrl_q.selop;
  assign shamt      = '0;
  assign busB_addr  = ctrl_q.bus_b;
  assign busC_addr  = ctrl_q.bus_c;
  assign halted     = ctrl_q.halted;
  assign illegal    = illegal_q;
  assign state_m    = state;

endmodule

// File: tb/tb_memsys_sequencer.sv
// Bench: sequencer driving a small behavioural memory_system, checked cycle by
// cycle against a control trace produced by an instruction-level program model.
module tb_memsys_sequencer;
  import memsys_pkg::*;

  typedef logic [21:0] cw_t;
  localparam cw_t W_CLR  = 22'h30_0000;
  localparam cw_t W_HLT  = 22'h00_1000;
  localparam cw_t W_ILL  = 22'h00_1800;
  localparam cw_t W_ZERO = 22'h00_0000;

  logic clk = 1'b0;
  logic rst, run;
  logic [4:0] instruction;
  logic C, N, P, Z;
  logic ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, wr_rdn, mdr_alu_n, mdr_en;
  logic [2:0] selop, busB_addr, busC_addr;
  logic [1:0] shamt;
  logic halted, illegal;
  logic [4:0] state_m;

  always #5 clk = ~clk;

  memsys_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .instruction(instruction),
    .C(C), .N(N), .P(P), .Z(Z),
    .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .bank_wr_en(bank_wr_en),
    .ir_en(ir_en), .mar_en(mar_en), .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n),
    .mdr_en(mdr_en), .selop(selop), .shamt(shamt), .busB_addr(busB_addr),
    .busC_addr(busC_addr), .halted(halted), .illegal(illegal), .state_m(state_m)
  );

  cw_t dut_cw;
  assign dut_cw = {ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, wr_rdn,
                   mdr_alu_n, mdr_en, halted, illegal, selop, busB_addr, busC_addr, shamt};

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural memory_system: register bank, MAR/MDR/IR, ALU, flags, RAM.
  logic [7:0] regs [8];
  logic [7:0] mem  [256];
  logic [7:0] rom  [256];
  logic [7:0] mar, mdr, last_fetch, bb;
  logic [8:0] alu;
  logic [4:0] ir;
  logic fc, fn, fp, fz, dp_load;
  int enaf_cnt, wr_cnt;

  assign instruction = ir;
  assign {C, N, P, Z} = {fc, fn, fp, fz};

  always @(posedge clk) begin
    if (dp_load) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      for (int i = 0; i < 256; i++) mem[i] <= rom[i];
      {mar, mdr, ir, last_fetch} <= '0;
      {fc, fn, fp, fz} <= 4'b0000;
      enaf_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      bb = regs[busB_addr];
      case (selop)
        3'b001:  alu = {1'b0, bb} + {1'b0, regs[4]};
        3'b110:  alu = {1'b0, bb} + 9'd1;
        default: alu = {1'b0, bb};
      endcase
      if (ir_sclr) ir <= '0;
      else if (ir_en) begin
        ir <= mdr[4:0];
        last_fetch <= mar;
      end
      if (mar_sclr) mar <= '0;
      else if (mar_en) mar <= bb;
      if (mdr_en && !wr_rdn) mdr <= mem[mar];
      if (wr_rdn) begin
        mem[mar] <= bb;
        wr_cnt <= wr_cnt + 1;
      end
      if (bank_wr_en) regs[busC_addr] <= mdr_alu_n ? mdr : alu[7:0];
      if (enaf) begin
        fc <= alu[8];
        fn <= alu[7];
        fp <= ^alu[7:0];
        fz <= (alu[7:0] == 8'h00);
        enaf_cnt <= enaf_cnt + 1;
      end
    end
  end

  // Instruction-level model: steps the program and lists the control word of every cycle.
  cw_t exp_q[$];
  logic [7:0] exp_pc, exp_a, exp_dptr, exp_m40;
  logic chk_on;

  function automatic cw_t mk(input logic ef, bwe, iren, maren, wr, malu, mdren,
                             input logic [2:0] sel, b, c);
    return {2'b00, ef, bwe, iren, maren, wr, malu, mdren, 2'b00, sel, b, c, 2'b00};
  endfunction

  function automatic cw_t wb(input logic [2:0] r);
    return mk(0, 1, 0, 0, 0, 1, 0, 3'd0, 3'd0, r);
  endfunction

  task automatic build_trace();
    logic [7:0] m [256];
    logic [7:0] pc, a, dptr, k;
    logic [8:0] s;
    logic [4:0] op;
    logic zf;
    bit done;
    m = rom;
    {pc, a, dptr, zf, done} = '0;
    exp_q.delete();
    for (int n = 0; n < 32 && !done; n++) begin
      op = m[pc][4:0];
      exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 3'd0));
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3'd6, 3'd0, 3'd0));
      exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));
      exp_q.push_back(W_ZERO);
      pc = pc + 8'd1;
      case (op)
        5'h00: ;
        5'h01, 5'h02, 5'h05, 5'h07: begin
          exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 3'd0));
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3'd6, 3'd0, 3'd0));
          k = m[pc];
          pc = pc + 8'd1;
          if (op == 5'h01) begin exp_q.push_back(wb(3'd2)); dptr = k; end
          if (op == 5'h02) begin exp_q.push_back(wb(3'd3)); a = k; end
          if (op == 5'h05) begin
            exp_q.push_back(wb(3'd4));
            exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'd1, 3'd3, 3'd3));
            s = {1'b0, a} + {1'b0, k};
            a = s[7:0];
            zf = (a == 8'h00);
          end
          if (op == 5'h07 && zf) begin exp_q.push_back(wb(3'd0)); pc = k; end
        end
        5'h03: begin
          exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd2, 3'd0));
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'd0, 3'd0, 3'd0));
          exp_q.push_back(wb(3'd3));
          a = m[dptr];
        end
        5'h04: begin
          exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3'd0, 3'd2, 3'd0));
          exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3'd0, 3'd3, 3'd0));
          m[dptr] = a;
        end
        5'h06: begin
          exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'd6, 3'd2, 3'd2));
          dptr = dptr + 8'd1;
          zf = (dptr == 8'h00);
        end
        5'h1F: begin
          repeat (3) exp_q.push_back(W_HLT);
          done = 1'b1;
        end
        default: begin
          repeat (3) exp_q.push_back(W_ILL);
          done = 1'b1;
        end
      endcase
    end
    exp_pc = pc;
    exp_a = a;
    exp_dptr = dptr;
    exp_m40 = m[8'h40];
  endtask

  // Per-cycle comparison of every control output against the model's trace.
  always @(posedge clk) begin
    cw_t e;
    #1;
    if (chk_on && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ctrl_word", 32'(dut_cw), 32'(e));
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h1F;
  endtask

  task automatic start_prog();
    build_trace();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; dp_load = 1'b1; chk_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'(dut_cw), 32'(W_CLR));
    chk("rst_state", 32'(state_m), 32'(S_CLR));
    dp_load = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", 32'(dut_cw), 32'(W_ZERO));
    chk("idle_state", 32'(state_m), 32'(S_IDLE));
    @(negedge clk);
    chk("idle_hold", 32'(state_m), 32'(S_IDLE));
    run = 1'b1;
    chk_on = 1'b1;
  endtask

  task automatic finish_prog();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("trace_left", 32'(exp_q.size()), 32'd0);
    chk_on = 1'b0;
    chk("arch_pc", 32'(regs[0]), 32'(exp_pc));
    chk("arch_a", 32'(regs[3]), 32'(exp_a));
    chk("arch_dptr", 32'(regs[2]), 32'(exp_dptr));
    chk("arch_m40", 32'(mem[8'h40]), 32'(exp_m40));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dp_load = 1'b1; chk_on = 1'b0;

    // MOV DPTR,#3C then HALT
    clear_rom();
    rom[0] = 8'h01; rom[1] = 8'h3C;
    start_prog();
    repeat (8) @(posedge clk);
    #2;
    chk("dptr_after_7", 32'(regs[2]), 32'h3C);
    chk("pc_after_7", 32'(regs[0]), 32'h02);
    finish_prog();

    // MOV A,#05; ADD A,#FF
    clear_rom();
    rom[0] = 8'h02; rom[1] = 8'h05; rom[2] = 8'h05; rom[3] = 8'hFF;
    start_prog();
    finish_prog();
    chk("add_a", 32'(regs[3]), 32'h04);
    chk("add_c", 32'(fc), 32'd1);
    chk("add_z", 32'(fz), 32'd0);
    chk("enaf_pulses", 32'(enaf_cnt), 32'd1);

    // JZ taken: A=01+FF=00
    clear_rom();
    rom[0] = 8'h02; rom[1] = 8'h01; rom[2] = 8'h05; rom[3] = 8'hFF;
    rom[4] = 8'h07; rom[5] = 8'h20;
    start_prog();
    finish_prog();
    chk("jz_taken_fetch", 32'(last_fetch), 32'h20);

    // JZ not taken: A=05+FF=04
    rom[1] = 8'h05;
    start_prog();
    finish_prog();
    chk("jz_fall_fetch", 32'(last_fetch), 32'h06);

    // Store A to @DPTR, clobber A, load it back
    clear_rom();
    rom[0] = 8'h01; rom[1] = 8'h40; rom[2] = 8'h02; rom[3] = 8'h5A;
    rom[4] = 8'h04; rom[5] = 8'h02; rom[6] = 8'h00; rom[7] = 8'h03;
    start_prog();
    finish_prog();
    chk("store_m40", 32'(mem[8'h40]), 32'h5A);
    chk("load_a", 32'(regs[3]), 32'h5A);
    chk("wr_pulses", 32'(wr_cnt), 32'd1);

    // NOP; MOV DPTR,#FF; INC DPTR wraps to 00
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h01; rom[2] = 8'hFF; rom[3] = 8'h06;
    start_prog();
    finish_prog();
    chk("inc_dptr", 32'(regs[2]), 32'h00);
    chk("inc_c", 32'(fc), 32'd1);

    // Undefined opcode 10101
    clear_rom();
    rom[0] = 8'h15;
    start_prog();
    finish_prog();
    chk("illegal_flag", 32'(illegal), 32'd1);
    chk("halted_flag", 32'(halted), 32'd1);

    // Reset while ADD's WB(TEMP) is on the bus
    clear_rom();
    rom[0] = 8'h02; rom[1] = 8'h05; rom[2] = 8'h05; rom[3] = 8'hFF;
    start_prog();
    repeat (14) @(posedge clk);
    #2;
    chk("wb_temp_ctrl", 32'(dut_cw), 32'(wb(3'd4)));
    @(negedge clk);
    rst = 1'b1; run = 1'b0; chk_on = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_state", 32'(state_m), 32'(S_CLR));
    chk("abort_ctrl", 32'(dut_cw), 32'(W_CLR));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_a", 32'(regs[3]), 32'h05);
    chk("abort_idle", 32'(state_m), 32'(S_IDLE));
    exp_q.delete();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
